// File: rtl/aes_pkg.sv
// Shared constants and helpers for the AES ShiftRows datapath: legal column counts,
// row shift offsets, byte placement within a column-major state word, and buffer states.
package aes_pkg;

  localparam int NB_AES    = 4;
  localparam int NB_RIJ192 = 6;
  localparam int NB_RIJ256 = 8;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_ONE,
    BUF_FULL
  } buf_state_t;

  function automatic bit nb_legal(input int nb);
    return (nb == NB_AES) || (nb == NB_RIJ192) || (nb == NB_RIJ256);
  endfunction

  // Rijndael-256 uses a wider spread on rows 2 and 3.
  function automatic int sr_shift(input int nb, input int row);
    case (row)
      0:       return 0;
      1:       return 1;
      2:       return (nb == NB_RIJ256) ? 3 : 2;
      default: return (nb == NB_RIJ256) ? 4 : 3;
    endcase
  endfunction

  function automatic int byte_lsb(input int nb, input int row, input int col);
    return 32 * nb - 8 - 8 * (4 * col + row);
  endfunction

endpackage

// File: rtl/aes_shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation for an NB-column state.
module aes_shift_rows_perm
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [32*NB-1:0] in_data,
  input  logic             inv,
  output logic [32*NB-1:0] out_data
);

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int FWD_SRC = (c + sr_shift(NB, r)) % NB;
      localparam int INV_SRC = (c - sr_shift(NB, r) + NB) % NB;
      assign out_data[byte_lsb(NB, r, c) +: 8] = inv ? in_data[byte_lsb(NB, r, INV_SRC) +: 8]
                                                     : in_data[byte_lsb(NB, r, FWD_SRC) +: 8];
    end
  end

endmodule

// File: rtl/aes_shift_rows_pipe.sv
// Pipelined ShiftRows/InvShiftRows with a two-entry result buffer (main + skid), 1-cycle latency.
// Optional delivered-block counter blk_count when AES_SR_STATS_EN is defined.
module aes_shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [32*NB-1:0] in_data,
  input  logic             in_inv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [32*NB-1:0] out_data,
  output logic             out_inv
`ifdef AES_SR_STATS_EN
  ,
  output logic [15:0]      blk_count
`endif
);

  localparam int W = 32 * NB;

  if (!nb_legal(NB)) begin : g_bad_nb
    $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
  end

  buf_state_t   state, state_nxt;
  logic [W-1:0] perm_data, main_data, skid_data;
  logic         main_inv, skid_inv;
  logic         accept, deliver, load_main, load_skid, skid_to_main;

  aes_shift_rows_perm #(.NB(NB)) u_perm (
    .in_data  (in_data),
    .inv      (in_inv),
    .out_data (perm_data)
  );

  // in_ready decodes only registered state, so out_ready never reaches it combinationally.
  assign in_ready  = (state != BUF_FULL) && !rst;
  assign out_valid = (state != BUF_EMPTY);
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;
  assign out_data  = main_data;
  assign out_inv   = main_inv;

  always_ff @(posedge clk) begin
    if (rst) state <= BUF_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state)
      BUF_EMPTY: begin
        if (accept) begin
          load_main = 1'b1;
          state_nxt = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (accept && !deliver) begin
          load_skid = 1'b1;
          state_nxt = BUF_FULL;
        end else if (accept) begin
          load_main = 1'b1;
        end else if (deliver) begin
          state_nxt = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (deliver) begin
          skid_to_main = 1'b1;
          state_nxt    = BUF_ONE;
        end
      end
      default: state_nxt = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_data <= '0;
      main_inv  <= 1'b0;
      skid_data <= '0;
      skid_inv  <= 1'b0;
    end else begin
      if (load_main) begin
        main_data <= perm_data;
        main_inv  <= in_inv;
      end else if (skid_to_main) begin
        main_data <= skid_data;
        main_inv  <= skid_inv;
      end
      if (load_skid) begin
        skid_data <= perm_data;
        skid_inv  <= in_inv;
      end
    end
  end

`ifdef AES_SR_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)          blk_count <= 16'd0;
    else if (deliver) blk_count <= blk_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Self-checking bench: directed vectors plus a byte-array ShiftRows model and scoreboard per DUT.
module tb_aes_shift_rows_pipe;

  logic         clk = 1'b0;
  logic         rst;
  logic         v4, rdy4, i4, ov4, r4, oi4;
  logic [127:0] d4, od4;
  logic         v8, rdy8, i8, ov8, r8, oi8;
  logic [255:0] d8, od8;
`ifdef AES_SR_STATS_EN
  logic [15:0]  bc4, bc8;
`endif

  int tests = 0;
  int fails = 0;
  int dl4   = 0;
  logic [256:0] q4[$];
  logic [256:0] q8[$];

  always #5 clk = ~clk;

  aes_shift_rows_pipe #(.NB(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .in_data(d4), .in_inv(i4),
    .out_valid(ov4), .out_ready(r4), .out_data(od4), .out_inv(oi4)
`ifdef AES_SR_STATS_EN
    , .blk_count(bc4)
`endif
  );

  aes_shift_rows_pipe #(.NB(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .in_data(d8), .in_inv(i8),
    .out_valid(ov8), .out_ready(r8), .out_data(od8), .out_inv(oi8)
`ifdef AES_SR_STATS_EN
    , .blk_count(bc8)
`endif
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // State viewed as bytes b[4c+r]; out[r][c] = in[r][(c +/- sh(r)) mod nb].
  function automatic logic [255:0] model(input int nb, input logic [255:0] d, input bit inv);
    logic [255:0] o = '0;
    int sh[4];
    int w = 32 * nb;
    int src;
    sh[0] = 0;
    sh[1] = 1;
    sh[2] = (nb == 8) ? 3 : 2;
    sh[3] = (nb == 8) ? 4 : 3;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - sh[r] + nb) % nb : (c + sh[r]) % nb;
        o[w-1-8*(4*c+r) -: 8] = d[w-1-8*(4*src+r) -: 8];
      end
    return o;
  endfunction

  always @(negedge clk) begin
    logic [256:0] e;
    if (rst) begin
      check("in_ready4_during_reset", rdy4, 0);
      check("in_ready8_during_reset", rdy8, 0);
      q4.delete();
      q8.delete();
      dl4 = 0;
    end else begin
      check("in_ready4_vs_occupancy", rdy4, q4.size() < 2);
      check("out_valid4_vs_model", ov4, q4.size() != 0);
`ifdef AES_SR_STATS_EN
      check("blk_count4", bc4, dl4 % 65536);
`endif
      if (ov4 && q4.size() != 0) begin
        e = q4[0];
        check("out_data4", od4, e[127:0]);
        check("out_inv4", oi4, e[256]);
        if (r4) begin
          void'(q4.pop_front());
          dl4++;
        end
      end
      if (v4 && rdy4) q4.push_back({i4, model(4, {128'd0, d4}, i4)});

      check("in_ready8_vs_occupancy", rdy8, q8.size() < 2);
      check("out_valid8_vs_model", ov8, q8.size() != 0);
      if (ov8 && q8.size() != 0) begin
        e = q8[0];
        check("out_data8", od8, e[255:0]);
        check("out_inv8", oi8, e[256]);
        if (r8) void'(q8.pop_front());
      end
      if (v8 && rdy8) q8.push_back({i8, model(8, d8, i8)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the data.
  task automatic put4(input logic [127:0] d, input bit inv, input bit rnd);
    bit acc = 0;
    v4 = 1'b1; d4 = d; i4 = inv;
    if (rnd) r4 = 1'($urandom_range(0, 1));
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      if (rdy4) acc = 1;
      else begin
        step();
        if (rnd) r4 = 1'($urandom_range(0, 1));
      end
    end
    check("put4_accepted", acc, 1);
    step();
    v4 = 1'b0;
    d4 = {$urandom, $urandom, $urandom, $urandom};
    i4 = 1'($urandom_range(0, 1));
  endtask

  task automatic put8(input logic [255:0] d, input bit inv);
    bit acc = 0;
    v8 = 1'b1; d8 = d; i8 = inv;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      if (rdy8) acc = 1;
      else step();
    end
    check("put8_accepted", acc, 1);
    step();
    v8 = 1'b0;
  endtask

  task automatic drain4();
    r4 = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!ov4) break;
    end
    check("drain4_empty", ov4, 0);
    step();
  endtask

  localparam logic [127:0] V1     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V1_FWD = 128'h00050a0f04090e03080d02070c01060b;
  localparam logic [127:0] FIPS   = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] FIPS_F = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [255:0] V8     = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] V8_FWD = 256'h00050e13_04091217_080d161b_0c111a1f_10151e03_14190207_181d060b_1c010a0f;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [127:0] bp[3];
    logic [255:0] x, y;
    int acc, idx, dl_before;
    logic last_rdy;

    rst = 1'b1; v4 = 0; r4 = 1; d4 = '0; i4 = 0; v8 = 0; r8 = 1; d8 = '0; i8 = 0;

    check("model_v1_fwd", model(4, {128'd0, V1}, 0), {128'd0, V1_FWD});
    check("model_fips_fwd", model(4, {128'd0, FIPS}, 0), {128'd0, FIPS_F});
    check("model_fips_inv", model(4, {128'd0, FIPS_F}, 1), {128'd0, FIPS});
    check("model_nb8_fwd", model(8, V8, 0), V8_FWD);

    step(); step();
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", ov4, 0);
    check("reset_in_ready", rdy4, 1);
    check("reset_out_data", od4, 0);
    check("reset_out_inv", oi4, 0);
    step();

    put4(V1, 0, 0);
    @(negedge clk);
    check("v1_out_valid", ov4, 1);
    check("v1_fwd_literal", od4, V1_FWD);
    step();
    put4(FIPS, 0, 0);
    @(negedge clk);
    check("fips_fwd_literal", od4, FIPS_F);
    step();
    put4(FIPS_F, 1, 0);
    @(negedge clk);
    check("fips_inv_literal", od4, FIPS);
    check("fips_inv_out_inv", oi4, 1);
    step();

    // Back-pressure: three offers with out_ready low, only two fit.
    bp[0] = 128'h11111111222222223333333344444444;
    bp[1] = 128'h55555555666666667777777788888888;
    bp[2] = 128'h99999999aaaaaaaabbbbbbbbcccccccc;
    dl_before = dl4;
    r4 = 1'b0; acc = 0; idx = 0; last_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v4 = 1'b1; d4 = bp[idx]; i4 = idx[0];
      @(negedge clk);
      last_rdy = rdy4;
      if (rdy4) begin acc++; idx++; end
      step();
    end
    check("bp_accepted_count", acc, 2);
    check("bp_in_ready_low", last_rdy, 0);
    check("bp_out_valid_held", ov4, 1);
    check("bp_out_data_held", od4, model(4, {128'd0, bp[0]}, 0));
    r4 = 1'b1;
    put4(bp[2], 0, 0);
    drain4();
    @(negedge clk);
    check("bp_in_ready_after", rdy4, 1);
    check("bp_delivered_count", dl4 - dl_before, 3);
    step();

    // Reset while FULL drops both buffered results.
    r4 = 1'b0;
    put4(bp[0], 1, 0);
    put4(bp[1], 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    r4 = 1'b1;
    @(negedge clk);
    check("rst_full_out_valid", ov4, 0);
    check("rst_full_in_ready", rdy4, 1);
    step(); step(); step();

    for (int i = 0; i < 24; i++)
      put4({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), 1);
    drain4();

    put8(V8, 0);
    @(negedge clk);
    check("nb8_fwd_literal", od8, V8_FWD);
    step();
    for (int i = 0; i < 4; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      put8(x, 0);
      @(negedge clk);
      y = od8;
      for (int c = 0; c < 8; c++)
        check("nb8_row2_shift3", y[255-8*(4*c+2) -: 8], x[255-8*(4*((c+3)%8)+2) -: 8]);
      step();
      put8(y, 1);
      @(negedge clk);
      check("nb8_round_trip", od8, x);
      check("nb8_round_trip_inv", oi8, 1);
      step();
    end

`ifdef AES_SR_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    r4 = 1'b1; v4 = 1'b1; d4 = V1; i4 = 1'b0;
    for (int i = 0; i < 65537; i++) step();
    v4 = 1'b0;
    step(); step();
    @(negedge clk);
    check("blk_count_wrap", bc4, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
